// File: rtl/bcd_time_keeper.sv
// rtl/bcd_time_keeper.sv - BCD 24-hour time keeper with button edit mode and RTC load/write-back
module bcd_time_keeper #(
   parameter int CLK_FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load_valid,
   input  logic [7:0] load_hr,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   input  logic       btn_mode,
   input  logic       btn_inc,
   output logic [7:0] hr,
   output logic [7:0] min,
   output logic [7:0] sec,
   output logic [1:0] edit_field,
   output logic       tick,
   output logic       wr_valid,
   input  logic       wr_ready
);

   localparam int DW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_FREQ - 1);

   typedef enum logic [2:0] {RUN, SET_HR, SET_MIN, SET_SEC, COMMIT} state_e;

   state_e          state_q, state_d;
   logic [DW-1:0]   div_q, div_d;
   logic            tick_q, tick_d;
   logic [7:0]      hr_q, hr_d, min_q, min_d, sec_q, sec_d;
   logic            mode_prev_q, inc_prev_q;
   logic            mode_rise, inc_rise, load_ok;

   // Both digits must be decimal; binary compare is then equivalent to decimal compare.
   function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] maxv);
      return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= maxv);
   endfunction

   // Increment a two-digit BCD value, wrapping to zero after maxv.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] maxv);
      if (v == maxv)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign mode_rise = btn_mode & ~mode_prev_q;
   assign inc_rise  = btn_inc & ~inc_prev_q;
   assign load_ok   = load_valid && bcd_ok(load_hr, 8'h23) &&
                      bcd_ok(load_min, 8'h59) && bcd_ok(load_sec, 8'h59);

   // Next-state: mode FSM, divider, pending second increment, loads and field edits.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      tick_d  = 1'b0;
      hr_d    = hr_q;
      min_d   = min_q;
      sec_d   = sec_q;
      unique case (state_q)
         RUN: begin
            // tick_q is the pending increment from the previous cycle's tick
            if (tick_q) begin
               if (sec_q == 8'h59) begin
                  sec_d = 8'h00;
                  if (min_q == 8'h59) begin
                     min_d = 8'h00;
                     hr_d  = bcd_inc(hr_q, 8'h23);
                  end else begin
                     min_d = bcd_inc(min_q, 8'h59);
                  end
               end else begin
                  sec_d = bcd_inc(sec_q, 8'h59);
               end
            end
            if (load_ok) begin
               hr_d  = load_hr;
               min_d = load_min;
               sec_d = load_sec;
               div_d = '0;
            end else if (div_q == DIV_MAX) begin
               div_d  = '0;
               tick_d = ~mode_rise;
            end else begin
               div_d = div_q + 1'b1;
            end
            if (mode_rise) begin
               state_d = SET_HR;
               div_d   = '0;
            end
         end
         SET_HR: begin
            div_d = '0;
            if (mode_rise)     state_d = SET_MIN;
            else if (inc_rise) hr_d = bcd_inc(hr_q, 8'h23);
         end
         SET_MIN: begin
            div_d = '0;
            if (mode_rise)     state_d = SET_SEC;
            else if (inc_rise) min_d = bcd_inc(min_q, 8'h59);
         end
         SET_SEC: begin
            div_d = '0;
            if (mode_rise)     state_d = COMMIT;
            else if (inc_rise) sec_d = bcd_inc(sec_q, 8'h59);
         end
         COMMIT: begin
            div_d = '0;
            if (wr_ready) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         div_q       <= '0;
         tick_q      <= 1'b0;
         hr_q        <= 8'h00;
         min_q       <= 8'h00;
         sec_q       <= 8'h00;
         mode_prev_q <= 1'b0;
         inc_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         tick_q      <= tick_d;
         hr_q        <= hr_d;
         min_q       <= min_d;
         sec_q       <= sec_d;
         mode_prev_q <= btn_mode;
         inc_prev_q  <= btn_inc;
      end
   end

   // Output decode from registered state.
   always_comb begin
      edit_field = 2'd0;
      unique case (state_q)
         SET_HR:  edit_field = 2'd1;
         SET_MIN: edit_field = 2'd2;
         SET_SEC: edit_field = 2'd3;
         default: edit_field = 2'd0;
      endcase
   end

   assign wr_valid = (state_q == COMMIT);
   assign tick     = tick_q;
   assign hr       = hr_q;
   assign min      = min_q;
   assign sec      = sec_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// tb/tb_bcd_time_keeper.sv - table-driven bench for bcd_time_keeper at CLK_FREQ = 4
module tb_bcd_time_keeper;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_valid;
   logic [7:0] load_hr, load_min, load_sec;
   logic       btn_mode, btn_inc, wr_ready;
   logic [7:0] hr, min, sec;
   logic [1:0] edit_field;
   logic       tick, wr_valid;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic       lv;
      logic [7:0] lh, lm, ls;
      logic       md, inc, rdy;
      logic [7:0] eh, em, es;
      logic [1:0] ed;
      logic       tk, wv;
   } vec_t;

   vec_t vq[$];

   bcd_time_keeper #(.CLK_FREQ(4)) dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_hr(load_hr), .load_min(load_min), .load_sec(load_sec),
      .btn_mode(btn_mode), .btn_inc(btn_inc),
      .hr(hr), .min(min), .sec(sec),
      .edit_field(edit_field), .tick(tick),
      .wr_valid(wr_valid), .wr_ready(wr_ready)
   );

   always #5 clk = ~clk;

   task automatic add(input logic lv, input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls,
                      input logic md, input logic inc, input logic rdy,
                      input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                      input logic [1:0] ed, input logic tk, input logic wv);
      vec_t v;
      v.lv = lv; v.lh = lh; v.lm = lm; v.ls = ls; v.md = md; v.inc = inc; v.rdy = rdy;
      v.eh = eh; v.em = em; v.es = es; v.ed = ed; v.tk = tk; v.wv = wv;
      vq.push_back(v);
   endtask

   task automatic idle(input int n, input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                       input logic [1:0] ed, input logic wv);
      for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, eh, em, es, ed, 0, wv);
   endtask

   task automatic check_all(input string tag, input logic [7:0] eh, input logic [7:0] em,
                            input logic [7:0] es, input logic [1:0] ed, input logic tk, input logic wv);
      n_vec++;
      if ({hr, min, sec} !== {eh, em, es}) begin
         n_err++;
         $display("FAIL %s time: got %h:%h:%h expected %h:%h:%h", tag, hr, min, sec, eh, em, es);
      end
      if (edit_field !== ed) begin
         n_err++;
         $display("FAIL %s edit_field: got %0d expected %0d", tag, edit_field, ed);
      end
      if (tick !== tk) begin
         n_err++;
         $display("FAIL %s tick: got %b expected %b", tag, tick, tk);
      end
      if (wr_valid !== wv) begin
         n_err++;
         $display("FAIL %s wr_valid: got %b expected %b", tag, wr_valid, wv);
      end
   endtask

   initial begin
      int cnt;
      rst = 1'b1; load_valid = 0; load_hr = 0; load_min = 0; load_sec = 0;
      btn_mode = 0; btn_inc = 0; wr_ready = 0;

      // run from reset: first tick CLK_FREQ edges after release
      idle(3, 8'h00, 8'h00, 8'h00, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      idle(1, 8'h00, 8'h00, 8'h01, 0, 0);
      // load 23:59:58 and roll over twice
      add(1, 8'h23, 8'h59, 8'h58, 0, 0, 0, 8'h23, 8'h59, 8'h58, 0, 0, 0);
      idle(3, 8'h23, 8'h59, 8'h58, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8'h23, 8'h59, 8'h58, 0, 1, 0);
      idle(3, 8'h23, 8'h59, 8'h59, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8'h23, 8'h59, 8'h59, 0, 1, 0);
      idle(1, 8'h00, 8'h00, 8'h00, 0, 0);
      // invalid loads leave time and divider alone (tick still lands on schedule)
      add(1, 8'h24, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
      add(1, 8'h12, 8'h5A, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
      add(1, 8'h12, 8'h30, 8'h0A, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 0);
      // load beats the pending increment
      add(1, 8'h10, 8'h20, 8'h30, 0, 0, 0, 8'h10, 8'h20, 8'h30, 0, 0, 0);
      add(1, 8'h00, 8'h59, 8'h07, 0, 0, 0, 8'h00, 8'h59, 8'h07, 0, 0, 0);
      // edit hours
      add(0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h59, 8'h07, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 8'h01, 8'h59, 8'h07, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8'h01, 8'h59, 8'h07, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 8'h02, 8'h59, 8'h07, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 8'h02, 8'h59, 8'h07, 1, 0, 0);
      // edit minutes: 59 wraps with no carry, load ignored
      add(0, 0, 0, 0, 1, 0, 0, 8'h02, 8'h59, 8'h07, 2, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 8'h02, 8'h00, 8'h07, 2, 0, 0);
      add(1, 8'h11, 8'h11, 8'h11, 0, 0, 0, 8'h02, 8'h00, 8'h07, 2, 0, 0);
      // edit seconds, divider frozen
      add(0, 0, 0, 0, 1, 0, 0, 8'h02, 8'h00, 8'h07, 3, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 8'h02, 8'h00, 8'h08, 3, 0, 0);
      idle(5, 8'h02, 8'h00, 8'h08, 3, 0);
      // commit with wr_ready low: buttons and load ignored
      add(0, 0, 0, 0, 1, 0, 0, 8'h02, 8'h00, 8'h08, 0, 0, 1);
      add(0, 0, 0, 0, 0, 1, 0, 8'h02, 8'h00, 8'h08, 0, 0, 1);
      add(0, 0, 0, 0, 1, 0, 0, 8'h02, 8'h00, 8'h08, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 0, 8'h02, 8'h00, 8'h08, 0, 0, 1);
      add(1, 8'h05, 8'h05, 8'h05, 0, 0, 0, 8'h02, 8'h00, 8'h08, 0, 0, 1);
      add(0, 0, 0, 0, 0, 0, 1, 8'h02, 8'h00, 8'h08, 0, 0, 0);
      // back in RUN with divider at 0
      idle(3, 8'h02, 8'h00, 8'h08, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8'h02, 8'h00, 8'h08, 0, 1, 0);
      idle(1, 8'h02, 8'h00, 8'h09, 0, 0);
      // simultaneous mode and inc edges in SET_HR
      add(0, 0, 0, 0, 1, 0, 0, 8'h02, 8'h00, 8'h09, 1, 0, 0);
      add(0, 0, 0, 0, 0, 1, 0, 8'h03, 8'h00, 8'h09, 1, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8'h03, 8'h00, 8'h09, 1, 0, 0);
      add(0, 0, 0, 0, 1, 1, 0, 8'h03, 8'h00, 8'h09, 2, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8'h03, 8'h00, 8'h09, 2, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 8'h03, 8'h00, 8'h09, 3, 0, 0);
      add(0, 0, 0, 0, 0, 0, 0, 8'h03, 8'h00, 8'h09, 3, 0, 0);
      add(0, 0, 0, 0, 1, 0, 0, 8'h03, 8'h00, 8'h09, 0, 0, 1);

      @(posedge clk); @(posedge clk); #1;
      check_all("reset", 8'h00, 8'h00, 8'h00, 0, 0, 0);
      rst = 1'b0;

      foreach (vq[i]) begin
         load_valid = vq[i].lv; load_hr = vq[i].lh; load_min = vq[i].lm; load_sec = vq[i].ls;
         btn_mode = vq[i].md; btn_inc = vq[i].inc; wr_ready = vq[i].rdy;
         @(posedge clk); #1;
         check_all($sformatf("row%0d", i + 1), vq[i].eh, vq[i].em, vq[i].es, vq[i].ed, vq[i].tk, vq[i].wv);
      end
      btn_mode = 0; btn_inc = 0; load_valid = 0; wr_ready = 0;

      // asynchronous reset mid-COMMIT takes effect before the next edge
      #3 rst = 1'b1;
      #1 check_all("async_rst", 8'h00, 8'h00, 8'h00, 0, 0, 0);
      @(posedge clk); #1;
      check_all("rst_held", 8'h00, 8'h00, 8'h00, 0, 0, 0);
      rst = 1'b0;

      // first tick after release, bounded wait
      cnt = 0;
      while (tick !== 1'b1 && cnt < 12) begin
         @(posedge clk); #1;
         cnt++;
      end
      n_vec++;
      if (cnt != 4) begin
         n_err++;
         $display("FAIL first_tick_latency: got %0d edges expected 4", cnt);
      end
      @(posedge clk); #1;
      check_all("post_rst_sec", 8'h00, 8'h00, 8'h01, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
